// File: rtl/serial_number_encoder_if.sv
// Handshake bundle for serial_number_encoder: number intake from the matrix
// encoder plus the character stream to the UART transmitter.
interface serial_number_encoder_if #(
   parameter int NUMBER_BITS = 37
);
   logic [NUMBER_BITS-1:0] number;
   logic                   ready;
   logic                   available;
   logic [7:0]             char_out;
   logic                   char_ready;
   logic                   tx_available;

   modport master (
      output number, ready, tx_available,
      input  available, char_out, char_ready
   );

   modport slave (
      input  number, ready, tx_available,
      output available, char_out, char_ready
   );
endinterface

// File: rtl/serial_number_encoder.sv
// Converts signed numbers to ASCII decimal text ('-', digits, terminator), one char per UART handshake.
// Optional macro SERIAL_NUMBER_ENCODER_NEWLINE_EN ends every GROUP_SIZE-th number with NEWLINE.
module serial_number_encoder #(
   parameter int         NUMBER_BITS = 37,
   parameter logic [7:0] SEPARATOR   = 8'h2C
`ifdef SERIAL_NUMBER_ENCODER_NEWLINE_EN
   ,
   parameter logic [7:0] NEWLINE     = 8'h0A,
   parameter int         GROUP_SIZE  = 8
`endif
) (
   input logic                   clk,
   input logic                   reset,
   serial_number_encoder_if.slave bus
);

   function automatic int digit_count(input int bits);
      logic [127:0] v;
      int           n;
      v = 128'd1 << (bits - 1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (v != 128'd0) begin
            v = v / 128'd10;
            n++;
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   localparam int DIGITS = digit_count(NUMBER_BITS);
   localparam int BCD_W  = 4 * DIGITS;
   localparam int CNT_W  = $clog2(NUMBER_BITS);
   localparam int IDX_W  = $clog2(DIGITS);

   // Double-dabble correction: every BCD nibble of 5 or more gets 3 added before the shift.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         else                     r[4*i +: 4] = r[4*i +: 4];
      end
      return r;
   endfunction

   typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_SIGN, S_DIGITS, S_SEP} state_t;

   state_t                 state_r, state_n;
   logic [NUMBER_BITS-1:0] mag_r, mag_in_s;
   logic                   neg_r;
   logic [BCD_W-1:0]       bcd_r, bcd_adj_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [IDX_W-1:0]       idx_r;
   logic                   started_r;
   logic                   tx_wait_r, tx_prev_r;
   logic                   available_r, char_ready_r;
   logic [7:0]             char_out_r;
   logic                   accept_s, can_issue_s, tx_rise_s, issue_s, skip_s;
   logic [7:0]             issue_char_s, term_s;
   logic [3:0]             nib_s;

`ifdef SERIAL_NUMBER_ENCODER_NEWLINE_EN
   localparam int GRP_W = $clog2(GROUP_SIZE);
   logic [GRP_W-1:0] group_r;
   logic             group_last_s;
   assign group_last_s = (group_r == GRP_W'(GROUP_SIZE - 1));
   assign term_s       = group_last_s ? NEWLINE : SEPARATOR;
`else
   assign term_s = SEPARATOR;
`endif

   assign accept_s    = (state_r == S_IDLE) && bus.ready && available_r;
   assign can_issue_s = bus.tx_available && !tx_wait_r;
   assign tx_rise_s   = bus.tx_available && !tx_prev_r;
   // Two's-complement negate is exact for the most negative value when read as unsigned.
   assign mag_in_s    = bus.number[NUMBER_BITS-1] ? (~bus.number + {{(NUMBER_BITS-1){1'b0}}, 1'b1})
                                                  : bus.number;
   assign bcd_adj_s   = add3(bcd_r);
   assign nib_s       = bcd_r[{idx_r, 2'b00} +: 4];

   // Next-state and character-issue decode.
   always_comb begin
      state_n      = state_r;
      issue_s      = 1'b0;
      issue_char_s = 8'h00;
      skip_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (accept_s) state_n = S_CONVERT;
            else          state_n = S_IDLE;
         end
         S_CONVERT: begin
            if (cnt_r == CNT_W'(NUMBER_BITS - 1)) state_n = S_SIGN;
            else                                  state_n = S_CONVERT;
         end
         S_SIGN: begin
            if (!neg_r) begin
               state_n = S_DIGITS;
            end else if (can_issue_s) begin
               issue_s      = 1'b1;
               issue_char_s = 8'h2D;
               state_n      = S_DIGITS;
            end else begin
               state_n = S_SIGN;
            end
         end
         S_DIGITS: begin
            if (!started_r && (nib_s == 4'd0) && (idx_r != {IDX_W{1'b0}})) begin
               skip_s = 1'b1;
            end else if (can_issue_s) begin
               issue_s      = 1'b1;
               issue_char_s = 8'h30 + {4'h0, nib_s};
               if (idx_r == {IDX_W{1'b0}}) state_n = S_SEP;
               else                        state_n = S_DIGITS;
            end else begin
               state_n = S_DIGITS;
            end
         end
         S_SEP: begin
            if (can_issue_s) begin
               issue_s      = 1'b1;
               issue_char_s = term_s;
               state_n      = S_IDLE;
            end else begin
               state_n = S_SEP;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= S_IDLE;
         mag_r        <= {NUMBER_BITS{1'b0}};
         neg_r        <= 1'b0;
         bcd_r        <= {BCD_W{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         idx_r        <= {IDX_W{1'b0}};
         started_r    <= 1'b0;
         tx_wait_r    <= 1'b0;
         tx_prev_r    <= 1'b0;
         available_r  <= 1'b1;
         char_ready_r <= 1'b0;
         char_out_r   <= 8'h00;
`ifdef SERIAL_NUMBER_ENCODER_NEWLINE_EN
         group_r      <= {GRP_W{1'b0}};
`endif
      end else begin
         state_r      <= state_n;
         tx_prev_r    <= bus.tx_available;
         char_ready_r <= issue_s;
         available_r  <= (state_r == S_IDLE) && !accept_s;
         if (issue_s)        tx_wait_r <= 1'b1;
         else if (tx_rise_s) tx_wait_r <= 1'b0;
         else                tx_wait_r <= tx_wait_r;
         if (issue_s) char_out_r <= issue_char_s;
         else         char_out_r <= char_out_r;
         if (accept_s) begin
            neg_r     <= bus.number[NUMBER_BITS-1];
            mag_r     <= mag_in_s;
            bcd_r     <= {BCD_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            idx_r     <= IDX_W'(DIGITS - 1);
            started_r <= 1'b0;
         end else if (state_r == S_CONVERT) begin
            bcd_r <= {bcd_adj_s[BCD_W-2:0], mag_r[NUMBER_BITS-1]};
            mag_r <= {mag_r[NUMBER_BITS-2:0], 1'b0};
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else if ((state_r == S_DIGITS) && (skip_s || issue_s)) begin
            if (issue_s) started_r <= 1'b1;
            else         started_r <= started_r;
            if (idx_r != {IDX_W{1'b0}}) idx_r <= idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
            else                        idx_r <= idx_r;
         end else begin
            cnt_r <= cnt_r;
         end
`ifdef SERIAL_NUMBER_ENCODER_NEWLINE_EN
         if ((state_r == S_SEP) && issue_s)
            group_r <= group_last_s ? {GRP_W{1'b0}} : group_r + {{(GRP_W-1){1'b0}}, 1'b1};
         else
            group_r <= group_r;
`endif
      end
   end

   assign bus.available  = available_r;
   assign bus.char_out   = char_out_r;
   assign bus.char_ready = char_ready_r;

endmodule
